// File: rtl/vga_rx_capture.sv
// -----------------------------------------------------------------------------
// vga_rx_capture
//
// Receive end of a VGA timing link. Samples hsync/vsync/rgb on vga_clk, tracks
// the horizontal position and line number, locks to the expected frame
// geometry and emits a valid-qualified pixel stream with recovered
// coordinates. Line-length, frame-length and blanking violations are flagged
// as single-cycle pulses and accumulated in a saturating error counter.
//
// Stream contract: pix_valid is a pure valid strobe with no back-pressure.
// pix_x/pix_y/pix_data are meaningful only in a cycle where pix_valid is 1,
// and every such cycle carries exactly one new pixel. frame_start is only
// ever high together with pix_valid, on pixel (0,0).
//
// Ports
//   vga_clk     in   1   pixel clock
//   sys_rst_n   in   1   asynchronous active-low reset
//   hsync       in   1   line sync, active-high pulse
//   vsync       in   1   frame sync, active-high pulse
//   rgb         in   16  RGB565 pixel, 0 during blanking
//   pix_valid   out  1   pix_x/pix_y/pix_data hold an active pixel
//   pix_x       out  10  column
//   pix_y       out  10  row
//   pix_data    out  16  captured rgb
//   frame_start out  1   pulse with pixel (0,0)
//   locked      out  1   high while in LOCKED
//   h_err       out  1   pulse: bad line length
//   v_err       out  1   pulse: bad frame length or misaligned vsync
//   blank_err   out  1   pulse: rgb != 0 outside the active window while LOCKED
//   err_cnt     out  8   saturating count of error pulses
//   dbg_state   out  2   current FSM state (0 SEARCH, 1 ALIGN, 2 LOCKED)
// -----------------------------------------------------------------------------
module vga_rx_capture #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 40,
    parameter int H_LEFT   = 8,
    parameter int H_VALID  = 640,
    parameter int H_RIGHT  = 8,
    parameter int H_FRONT  = 8,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 25,
    parameter int V_TOP    = 8,
    parameter int V_VALID  = 480,
    parameter int V_BOTTOM = 8,
    parameter int V_FRONT  = 2
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [15:0] rgb,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        frame_start,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic        blank_err,
    output logic [7:0]  err_cnt,
    output logic [1:0]  dbg_state
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;

    localparam logic [9:0] H_ACT_L   = 10'(H_SYNC + H_BACK + H_LEFT);
    localparam logic [9:0] H_END_L   = 10'(H_SYNC + H_BACK + H_LEFT + H_VALID);
    localparam logic [9:0] V_ACT_L   = 10'(V_SYNC + V_BACK + V_TOP);
    localparam logic [9:0] V_END_L   = 10'(V_SYNC + V_BACK + V_TOP + V_VALID);
    localparam logic [9:0] H_LAST_L  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST_L  = 10'(V_TOTAL - 1);
    localparam logic [9:0] CNT_MAX_L = 10'h3FF;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_hs_d;
    logic        r_vs_d;
    logic [9:0]  r_h_pos;    // h_pos of the previous sample
    logic [9:0]  r_v_line;   // v_line of the previous sample

    logic        w_hs_rise;
    logic        w_vs_rise;
    logic        w_coinc;
    logic [9:0]  w_h_pos;    // h_pos of the current sample
    logic [9:0]  w_v_line;   // v_line of the current sample
    logic        w_active;
    logic        w_h_err;
    logic        w_v_err_a;
    logic        w_v_err_b;
    logic        w_v_err;
    logic        w_blank_err;
    logic        w_pix_valid;
    logic        w_frame_start;
    logic [1:0]  w_err_inc;
    logic [8:0]  w_err_sum;

    // Edge detection and position recovery for the sample on the inputs now.
    always_comb begin
        w_hs_rise = hsync & ~r_hs_d;
        w_vs_rise = vsync & ~r_vs_d;
        w_coinc   = w_hs_rise & w_vs_rise;

        if (w_hs_rise) begin
            w_h_pos = 10'd0;
        end else if (r_h_pos == CNT_MAX_L) begin
            w_h_pos = r_h_pos;
        end else begin
            w_h_pos = r_h_pos + 10'd1;
        end

        // The line counter only moves on a line start; a coincident vsync
        // edge restarts the frame.
        if (!w_hs_rise) begin
            w_v_line = r_v_line;
        end else if (w_vs_rise) begin
            w_v_line = 10'd0;
        end else if (r_v_line == CNT_MAX_L) begin
            w_v_line = r_v_line;
        end else begin
            w_v_line = r_v_line + 10'd1;
        end

        w_active = (w_h_pos >= H_ACT_L) && (w_h_pos < H_END_L) &&
                   (w_v_line >= V_ACT_L) && (w_v_line < V_END_L);
    end

    // Error detection. Line/frame length checks look at the position of the
    // sample just before the edge, i.e. the last cycle of the old line/frame.
    always_comb begin
        w_h_err     = w_hs_rise && (r_state != ST_SEARCH) && (r_h_pos != H_LAST_L);
        w_v_err_a   = w_vs_rise && !w_hs_rise;
        w_v_err_b   = w_coinc && (r_state != ST_SEARCH) && (r_v_line != V_LAST_L);
        w_v_err     = w_v_err_a || w_v_err_b;
        w_blank_err = (r_state == ST_LOCKED) && !w_active && (rgb != 16'd0);

        w_err_inc = {1'b0, w_h_err} + {1'b0, w_v_err} + {1'b0, w_blank_err};
        w_err_sum = {1'b0, err_cnt} + {7'd0, w_err_inc};
    end

    // Next-state logic. A line-length fault or a stray vsync sends the
    // receiver back to SEARCH; a coincident edge with a wrong frame length
    // becomes the new reference (ALIGN). blank_err never affects the state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SEARCH: begin
                if (w_coinc) begin
                    w_state_next = ST_ALIGN;
                end
            end
            ST_ALIGN, ST_LOCKED: begin
                if (w_h_err || w_v_err_a) begin
                    w_state_next = ST_SEARCH;
                end else if (w_v_err_b) begin
                    w_state_next = ST_ALIGN;
                end else if (w_coinc) begin
                    w_state_next = ST_LOCKED;
                end
            end
            default: begin
                w_state_next = ST_SEARCH;
            end
        endcase
    end

    // Qualifying with the next state drops the stream on the very sample
    // that breaks lock. Lock is only gained at a frame start, so a frame is
    // never entered part-way and frame_start is never partial.
    always_comb begin
        w_pix_valid   = w_active && (w_state_next == ST_LOCKED);
        w_frame_start = w_pix_valid && (w_h_pos == H_ACT_L) && (w_v_line == V_ACT_L);
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_hs_d      <= 1'b0;
            r_vs_d      <= 1'b0;
            r_h_pos     <= 10'd0;
            r_v_line    <= 10'd0;
            pix_valid   <= 1'b0;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            pix_data    <= 16'd0;
            frame_start <= 1'b0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            blank_err   <= 1'b0;
            err_cnt     <= 8'd0;
        end else begin
            r_hs_d      <= hsync;
            r_vs_d      <= vsync;
            r_h_pos     <= w_h_pos;
            r_v_line    <= w_v_line;
            pix_valid   <= w_pix_valid;
            frame_start <= w_frame_start;
            h_err       <= w_h_err;
            v_err       <= w_v_err;
            blank_err   <= w_blank_err;
            // Coordinates and data only move with a new pixel.
            if (w_pix_valid) begin
                pix_x    <= w_h_pos - H_ACT_L;
                pix_y    <= w_v_line - V_ACT_L;
                pix_data <= rgb;
            end
            if (w_err_sum > 9'd255) begin
                err_cnt <= 8'd255;
            end else begin
                err_cnt <= w_err_sum[7:0];
            end
        end
    end

    assign locked    = (r_state == ST_LOCKED);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_vga_rx_capture.sv
// -----------------------------------------------------------------------------
// tb_vga_rx_capture
//
// Directed bench for vga_rx_capture using a shrunken frame geometry
// (18 x 10 totals, 8 x 4 active window starting at h 7 / line 4) so that many
// whole frames fit in a short run. Expected pixels are queued by the driver
// from the frame plan and popped by a monitor as pix_valid appears.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_rx_capture;

    localparam int TB_H_SYNC  = 4;
    localparam int TB_H_BACK  = 2;
    localparam int TB_H_LEFT  = 1;
    localparam int TB_H_VALID = 8;
    localparam int TB_H_RIGHT = 1;
    localparam int TB_H_FRONT = 2;
    localparam int TB_V_SYNC  = 2;
    localparam int TB_V_BACK  = 1;
    localparam int TB_V_TOP   = 1;
    localparam int TB_V_VALID = 4;
    localparam int TB_V_BOT   = 1;
    localparam int TB_V_FRONT = 1;
    localparam int TB_H_TOTAL = 18;
    localparam int TB_V_TOTAL = 10;
    localparam int TB_H_ACT   = 7;
    localparam int TB_V_ACT   = 4;
    localparam int PIX_PER_FRAME = TB_H_VALID * TB_V_VALID;

    // ---------------- clock / reset ----------------
    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic        hsync;
    logic        vsync;
    logic [15:0] rgb;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [15:0] pix_data;
    logic        frame_start;
    logic        locked;
    logic        h_err;
    logic        v_err;
    logic        blank_err;
    logic [7:0]  err_cnt;
    logic [1:0]  dbg_state;

    always #5 vga_clk = ~vga_clk;

    vga_rx_capture #(
        .H_SYNC   (TB_H_SYNC),
        .H_BACK   (TB_H_BACK),
        .H_LEFT   (TB_H_LEFT),
        .H_VALID  (TB_H_VALID),
        .H_RIGHT  (TB_H_RIGHT),
        .H_FRONT  (TB_H_FRONT),
        .V_SYNC   (TB_V_SYNC),
        .V_BACK   (TB_V_BACK),
        .V_TOP    (TB_V_TOP),
        .V_VALID  (TB_V_VALID),
        .V_BOTTOM (TB_V_BOT),
        .V_FRONT  (TB_V_FRONT)
    ) dut (
        .vga_clk     (vga_clk),
        .sys_rst_n   (sys_rst_n),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_data    (pix_data),
        .frame_start (frame_start),
        .locked      (locked),
        .h_err       (h_err),
        .v_err       (v_err),
        .blank_err   (blank_err),
        .err_cnt     (err_cnt),
        .dbg_state   (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    // Entry: {frame_start, pix_x, pix_y, pix_data}
    logic [36:0] exp_q[$];
    logic [36:0] mon_w;

    int          cnt_pix;
    int          cnt_fs;
    int          cnt_herr;
    int          cnt_verr;
    int          cnt_berr;
    logic        lock_at_herr;
    logic        lock_at_berr;
    logic [9:0]  fs_x;
    logic [9:0]  fs_y;
    logic [15:0] fs_data;
    logic [9:0]  last_x;
    logic [9:0]  last_y;

    task automatic clear_counts();
        cnt_pix  = 0;
        cnt_fs   = 0;
        cnt_herr = 0;
        cnt_verr = 0;
        cnt_berr = 0;
    endtask

    always @(posedge vga_clk) begin
        #1;
        if (pix_valid) begin
            cnt_pix++;
            last_x = pix_x;
            last_y = pix_y;
            check("pix_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                mon_w = exp_q.pop_front();
                check("pix_word", {27'd0, frame_start, pix_x, pix_y, pix_data}, {27'd0, mon_w});
            end
        end
        if (frame_start) begin
            cnt_fs++;
            fs_x    = pix_x;
            fs_y    = pix_y;
            fs_data = pix_data;
        end
        if (h_err) begin
            cnt_herr++;
            lock_at_herr = locked;
        end
        if (v_err) begin
            cnt_verr++;
        end
        if (blank_err) begin
            cnt_berr++;
            lock_at_berr = locked;
        end
    end

    // ---------------- driver ----------------
    int          exp_lim;     // active lines below this index are expected out
    logic        use_fixed;
    logic [15:0] fixed_rgb;
    int          inj_v;       // injection point (line, h); -1 disables
    int          inj_h;
    logic [15:0] inj_rgb;
    logic        inj_vs;

    function automatic logic [15:0] pix_val(input int x, input int y);
        if (use_fixed) begin
            return fixed_rgb;
        end
        return {1'b1, y[4:0], x[9:0]};
    endfunction

    task automatic drive_sample(input logic hs, input logic vs, input logic [15:0] d);
        hsync = hs;
        vsync = vs;
        rgb   = d;
        @(posedge vga_clk);
        #1;
    endtask

    // Drives one frame of 'lines' lines; line 'short_line' is one cycle short.
    // Returns early right after the sample (stop_v, stop_h) has been taken.
    task automatic drive_frame(input int lines, input int short_line,
                               input int stop_v, input int stop_h);
        int          len;
        logic        act;
        logic [15:0] d;
        logic        vs;
        for (int v = 0; v < lines; v++) begin
            len = (v == short_line) ? TB_H_TOTAL - 1 : TB_H_TOTAL;
            for (int h = 0; h < len; h++) begin
                act = (h >= TB_H_ACT) && (h < TB_H_ACT + TB_H_VALID) &&
                      (v >= TB_V_ACT) && (v < TB_V_ACT + TB_V_VALID);
                d  = act ? pix_val(h - TB_H_ACT, v - TB_V_ACT) : 16'h0000;
                vs = (v < TB_V_SYNC);
                if (v == inj_v && h == inj_h) begin
                    d = inj_rgb;
                    if (inj_vs) begin
                        vs = 1'b1;
                    end
                end
                if (act && v < exp_lim) begin
                    exp_q.push_back({(h == TB_H_ACT && v == TB_V_ACT),
                                     10'(h - TB_H_ACT), 10'(v - TB_V_ACT), d});
                end
                drive_sample(h < TB_H_SYNC, vs, d);
                if (v == stop_v && h == stop_h) begin
                    return;
                end
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "simulation time limit");
    end

    // ---------------- stimulus ----------------
    initial begin
        sys_rst_n    = 1'b0;
        hsync        = 1'b0;
        vsync        = 1'b0;
        rgb          = 16'h0000;
        exp_lim      = 0;
        use_fixed    = 1'b0;
        fixed_rgb    = 16'h0000;
        inj_v        = -1;
        inj_h        = -1;
        inj_rgb      = 16'h0000;
        inj_vs       = 1'b0;
        lock_at_herr = 1'b1;
        lock_at_berr = 1'b0;
        fs_x = '0; fs_y = '0; fs_data = '0; last_x = '0; last_y = '0;
        clear_counts();

        repeat (3) @(posedge vga_clk);
        #1;
        check("rst_outputs", {14'd0, pix_valid, pix_x, pix_y, pix_data, frame_start,
                              locked, h_err, v_err, blank_err, err_cnt}, 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        sys_rst_n = 1'b1;
        drive_sample(1'b0, 1'b0, 16'h0000);
        drive_sample(1'b0, 1'b0, 16'h0000);

        // 1: first frame aligns, second frame is locked and fully captured
        clear_counts();
        exp_lim = 0;
        drive_frame(TB_V_TOTAL, -1, -1, -1);
        check("t1_align_locked", 64'(locked), 64'd0);
        check("t1_align_state", 64'(dbg_state), 64'd1);
        check("t1_align_pix", 64'(cnt_pix), 64'd0);
        clear_counts();
        exp_lim = 1000;
        drive_frame(TB_V_TOTAL, -1, -1, -1);
        check("t1_locked", 64'(locked), 64'd1);
        check("t1_state", 64'(dbg_state), 64'd2);
        check("t1_pix_count", 64'(cnt_pix), 64'(PIX_PER_FRAME));
        check("t1_fs_count", 64'(cnt_fs), 64'd1);
        check("t1_err_cnt", 64'(err_cnt), 64'd0);
        check("t1_err_pulses", 64'(cnt_herr + cnt_verr + cnt_berr), 64'd0);
        check("t1_q_empty", 64'(exp_q.size()), 64'd0);

        // 2/2a: white frame, first and last pixel
        use_fixed = 1'b1;
        fixed_rgb = 16'hffff;
        clear_counts();
        drive_frame(TB_V_TOTAL, -1, -1, -1);
        use_fixed = 1'b0;
        check("t2_fs_count", 64'(cnt_fs), 64'd1);
        check("t2_fs_xy", {44'd0, fs_x, fs_y}, 64'd0);
        check("t2_fs_data", 64'(fs_data), 64'hffff);
        check("t2_last_x", 64'(last_x), 64'(TB_H_VALID - 1));
        check("t2_last_y", 64'(last_y), 64'(TB_V_VALID - 1));
        check("t2_pix_count", 64'(cnt_pix), 64'(PIX_PER_FRAME));
        check("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // 3/3a: short line breaks lock, relock after a full good frame
        clear_counts();
        exp_lim = 0;
        drive_frame(TB_V_TOTAL, 3, -1, -1);
        check("t3_herr_count", 64'(cnt_herr), 64'd1);
        check("t3_lock_at_herr", 64'(lock_at_herr), 64'd0);
        check("t3_verr_count", 64'(cnt_verr), 64'd0);
        check("t3_state", 64'(dbg_state), 64'd0);
        check("t3_err_cnt", 64'(err_cnt), 64'd1);
        drive_frame(TB_V_TOTAL, -1, -1, -1);
        check("t3_align_state", 64'(dbg_state), 64'd1);
        check("t3_align_locked", 64'(locked), 64'd0);
        clear_counts();
        exp_lim = 1000;
        drive_frame(TB_V_TOTAL, -1, -1, -1);
        check("t3_relocked", 64'(locked), 64'd1);
        check("t3_relock_pix", 64'(cnt_pix), 64'(PIX_PER_FRAME));
        check("t3_err_cnt_after", 64'(err_cnt), 64'd1);

        // 4/4a: frame one line short gives v_err at the next vsync
        clear_counts();
        drive_frame(TB_V_TOTAL - 1, -1, -1, -1);
        check("t4_short_frame_pix", 64'(cnt_pix), 64'(PIX_PER_FRAME));
        check("t4_short_frame_locked", 64'(locked), 64'd1);
        clear_counts();
        exp_lim = 0;
        drive_frame(TB_V_TOTAL, -1, -1, -1);
        check("t4_verr_count", 64'(cnt_verr), 64'd1);
        check("t4_herr_count", 64'(cnt_herr), 64'd0);
        check("t4_state", 64'(dbg_state), 64'd1);
        check("t4_locked", 64'(locked), 64'd0);
        check("t4_err_cnt", 64'(err_cnt), 64'd2);
        clear_counts();
        exp_lim = 1000;
        drive_frame(TB_V_TOTAL, -1, -1, -1);
        check("t4_relocked", 64'(locked), 64'd1);
        check("t4_relock_pix", 64'(cnt_pix), 64'(PIX_PER_FRAME));
        check("t4_q_empty", 64'(exp_q.size()), 64'd0);

        // 5: nonzero rgb in horizontal blanking keeps lock
        inj_v   = 5;
        inj_h   = 2;
        inj_rgb = 16'h0001;
        inj_vs  = 1'b0;
        clear_counts();
        drive_frame(TB_V_TOTAL, -1, -1, -1);
        check("t5_berr_count", 64'(cnt_berr), 64'd1);
        check("t5_lock_at_berr", 64'(lock_at_berr), 64'd1);
        check("t5_locked", 64'(locked), 64'd1);
        check("t5_pix_count", 64'(cnt_pix), 64'(PIX_PER_FRAME));
        check("t5_err_cnt", 64'(err_cnt), 64'd3);

        // 5b: stray vsync plus blanking fault in one sample: two pulses at once
        inj_v   = 6;
        inj_h   = 3;
        inj_vs  = 1'b1;
        exp_lim = 6;
        clear_counts();
        drive_frame(TB_V_TOTAL, -1, -1, -1);
        inj_v   = -1;
        check("t5b_verr_count", 64'(cnt_verr), 64'd1);
        check("t5b_berr_count", 64'(cnt_berr), 64'd1);
        check("t5b_err_cnt", 64'(err_cnt), 64'd5);
        check("t5b_state", 64'(dbg_state), 64'd0);
        check("t5b_pix_count", 64'(cnt_pix), 64'(2 * TB_H_VALID));
        check("t5b_q_empty", 64'(exp_q.size()), 64'd0);

        // 6: asynchronous reset in the middle of an active line
        exp_lim = 0;
        drive_frame(TB_V_TOTAL, -1, -1, -1);
        exp_lim = 1000;
        clear_counts();
        drive_frame(TB_V_TOTAL, -1, 5, 10);
        check("t6_pre_valid", 64'(pix_valid), 64'd1);
        check("t6_pre_locked", 64'(locked), 64'd1);
        #2;
        check("t6_pre_pix_count", 64'(cnt_pix), 64'(TB_H_VALID + 4));
        sys_rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", {14'd0, pix_valid, pix_x, pix_y, pix_data, frame_start,
                                 locked, h_err, v_err, blank_err, err_cnt}, 64'd0);
        check("t6_rst_state", 64'(dbg_state), 64'd0);
        exp_q.delete();
        hsync = 1'b0;
        vsync = 1'b0;
        rgb   = 16'h0000;
        repeat (2) @(posedge vga_clk);
        #3;
        sys_rst_n = 1'b1;
        @(posedge vga_clk);
        #1;

        // 6b: 300 stray vsync edges saturate the error counter
        clear_counts();
        for (int i = 0; i < 100; i++) begin
            drive_sample(1'b0, 1'b1, 16'h0000);
            drive_sample(1'b0, 1'b0, 16'h0000);
        end
        check("t6_err_cnt_100", 64'(err_cnt), 64'd100);
        for (int i = 0; i < 200; i++) begin
            drive_sample(1'b0, 1'b1, 16'h0000);
            drive_sample(1'b0, 1'b0, 16'h0000);
        end
        check("t6_err_cnt_sat", 64'(err_cnt), 64'd255);
        check("t6_verr_count", 64'(cnt_verr), 64'd300);
        check("t6_herr_count", 64'(cnt_herr), 64'd0);
        check("t6_locked", 64'(locked), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
